// File: rtl/ddr4_traffic_gen.sv
// ddr4_traffic_gen: writes NUM_BURSTS patterned beats over the MIG app_* interface, reads them back and compares.
// Define TG_LFSR_PATTERN_EN to use per-lane Galois LFSR data instead of the index-based pattern.
module ddr4_traffic_gen #(
    parameter int                        APP_ADDR_WIDTH = 28,
    parameter int                        APP_DATA_WIDTH = 512,
    parameter int                        NUM_BURSTS     = 256,
    parameter logic [APP_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                        ADDR_STEP      = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          init_calib_complete,
    input  logic                          app_rdy,
    output logic                          app_en,
    output logic [2:0]                    app_cmd,
    output logic [APP_ADDR_WIDTH-1:0]     app_addr,
    input  logic                          app_wdf_rdy,
    output logic                          app_wdf_wren,
    output logic                          app_wdf_end,
    output logic [APP_DATA_WIDTH-1:0]     app_wdf_data,
    output logic [APP_DATA_WIDTH/8-1:0]   app_wdf_mask,
    input  logic [APP_DATA_WIDTH-1:0]     app_rd_data,
    input  logic                          app_rd_data_valid,
    output logic                          busy,
    output logic                          done,
    output logic                          data_compare_error,
    output logic [15:0]                   err_count,
    output logic [15:0]                   first_err_idx,
    output logic                          calib_lost
);
    localparam int LANES = APP_DATA_WIDTH / 32;
    localparam int CW = $clog2(NUM_BURSTS + 1);
    localparam logic [CW-1:0] NB = CW'(NUM_BURSTS);
    localparam logic [APP_ADDR_WIDTH-1:0] STEP = APP_ADDR_WIDTH'(ADDR_STEP);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]             cmd_cnt, dat_cnt, rd_cnt;
    logic [APP_ADDR_WIDTH-1:0] addr;
    logic [APP_DATA_WIDTH-1:0] wr_pat, rd_pat;
    logic                      go, lost, cmd_acc, dat_acc, rd_acc, mismatch;

`ifdef TG_LFSR_PATTERN_EN
    localparam logic [31:0] POLY = 32'h8020_0003;
    localparam logic [31:0] SEED = 32'hACE1_2468;
    logic [31:0] wr_lfsr, rd_lfsr;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? (s >> 1) ^ POLY : s >> 1;
    endfunction

    function automatic logic [APP_DATA_WIDTH-1:0] lfsr_beat(input logic [31:0] s);
        logic [APP_DATA_WIDTH-1:0] d = '0;
        for (int i = 0; i < LANES; i++) begin
            d[32*i +: 32] = s;
            s = lfsr_step(s);
        end
        return d;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        for (int i = 0; i < LANES; i++) s = lfsr_step(s);
        return s;
    endfunction

    assign wr_pat = lfsr_beat(wr_lfsr);
    assign rd_pat = lfsr_beat(rd_lfsr);

    // Each generator advances only on its own accepted beat so write and compare stay aligned.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_lfsr <= SEED;
            rd_lfsr <= SEED;
        end else if (go) begin
            wr_lfsr <= SEED;
            rd_lfsr <= SEED;
        end else begin
            if (dat_acc) wr_lfsr <= lfsr_next(wr_lfsr);
            if (rd_acc) rd_lfsr <= lfsr_next(rd_lfsr);
        end
`else
    function automatic logic [APP_DATA_WIDTH-1:0] idx_beat(input logic [CW-1:0] k);
        logic [APP_DATA_WIDTH-1:0] d = '0;
        for (int i = 0; i < LANES; i++) d[32*i +: 32] = {16'(k), 16'(i)};
        return d;
    endfunction

    assign wr_pat = idx_beat(dat_cnt);
    assign rd_pat = idx_beat(rd_cnt);
`endif

    assign busy         = state inside {WRITE, READ, DRAIN};
    assign done         = state == DONE;
    assign app_wdf_mask = '0;
    assign app_wdf_end  = app_wdf_wren;

    // Command waits for its data beat; data may run at most two beats ahead of commands.
    always_comb begin
        go           = start & (state == IDLE ? init_calib_complete : state == DONE);
        lost         = busy & !init_calib_complete;
        app_en       = init_calib_complete & (state == WRITE ? cmd_cnt < dat_cnt : state == READ & cmd_cnt < NB);
        app_wdf_wren = init_calib_complete & state == WRITE & dat_cnt < NB &
                       ({1'b0, dat_cnt} < {1'b0, cmd_cnt} + (CW+1)'(2));
        app_cmd      = state == READ ? 3'b001 : 3'b000;
        app_addr     = app_en ? addr : '0;
        app_wdf_data = app_wdf_wren ? wr_pat : '0;
        cmd_acc      = app_en & app_rdy;
        dat_acc      = app_wdf_wren & app_wdf_rdy;
        rd_acc       = app_rd_data_valid & (state == READ | state == DRAIN) & rd_cnt < NB;
        mismatch     = rd_acc & (app_rd_data != rd_pat);
        state_nxt    = lost ? DONE :
                       go ? WRITE :
                       (state == WRITE && cmd_cnt == NB && dat_cnt == NB) ? READ :
                       (state == READ && cmd_cnt == NB) ? DRAIN :
                       (state == DRAIN && rd_cnt == NB) ? DONE : state;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state              <= IDLE;
            cmd_cnt            <= '0;
            dat_cnt            <= '0;
            rd_cnt             <= '0;
            addr               <= BASE_ADDR;
            data_compare_error <= 1'b0;
            err_count          <= '0;
            first_err_idx      <= '0;
            calib_lost         <= 1'b0;
        end else begin
            state <= state_nxt;
            if (go) begin
                cmd_cnt            <= '0;
                dat_cnt            <= '0;
                rd_cnt             <= '0;
                addr               <= BASE_ADDR;
                data_compare_error <= 1'b0;
                err_count          <= '0;
                first_err_idx      <= '0;
                calib_lost         <= 1'b0;
            end else begin
                if (state == WRITE && state_nxt == READ) begin
                    cmd_cnt <= '0;
                    addr    <= BASE_ADDR;
                end else if (cmd_acc) begin
                    cmd_cnt <= cmd_cnt + 1'b1;
                    addr    <= addr + STEP;
                end
                if (dat_acc) dat_cnt <= dat_cnt + 1'b1;
                if (rd_acc) rd_cnt <= rd_cnt + 1'b1;
                if (mismatch) begin
                    data_compare_error <= 1'b1;
                    if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                    if (err_count == '0) first_err_idx <= 16'(rd_cnt);
                end
                if (lost) begin
                    calib_lost         <= 1'b1;
                    data_compare_error <= 1'b1;
                end
            end
        end
endmodule

// File: tb/tb_ddr4_traffic_gen.sv
// tb_ddr4_traffic_gen: MIG-side responder with a memory model, table-driven passes and hand-written corner sequences.
module tb_ddr4_traffic_gen;
    localparam int AW = 28, DW = 128, NB = 4, STEP = 8;
    localparam logic [AW-1:0] WRAP_BASE = 28'hFFF_FFF8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, calib, app_rdy, app_wdf_rdy, app_rd_data_valid;
    logic [DW-1:0] app_rd_data;
    logic app_en, app_wdf_wren, app_wdf_end, busy, done, data_compare_error, calib_lost;
    logic [2:0] app_cmd;
    logic [AW-1:0] app_addr;
    logic [DW-1:0] app_wdf_data;
    logic [DW/8-1:0] app_wdf_mask;
    logic [15:0] err_count, first_err_idx;

    logic start2, en2, wren2, end2, busy2, done2, err2, lost2;
    logic [2:0] cmd2;
    logic [AW-1:0] addr2;
    logic [DW-1:0] wdata2;
    logic [DW/8-1:0] mask2;
    logic [15:0] cnt2, first2;

    ddr4_traffic_gen #(.APP_ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .NUM_BURSTS(NB), .BASE_ADDR('0), .ADDR_STEP(STEP)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .init_calib_complete(calib),
        .app_rdy(app_rdy), .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
        .app_wdf_rdy(app_wdf_rdy), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .busy(busy), .done(done), .data_compare_error(data_compare_error),
        .err_count(err_count), .first_err_idx(first_err_idx), .calib_lost(calib_lost));

    ddr4_traffic_gen #(.APP_ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .NUM_BURSTS(2), .BASE_ADDR(WRAP_BASE), .ADDR_STEP(STEP)) u_wrap (
        .clk(clk), .rst_n(rst_n), .start(start2), .init_calib_complete(calib),
        .app_rdy(1'b1), .app_en(en2), .app_cmd(cmd2), .app_addr(addr2),
        .app_wdf_rdy(1'b1), .app_wdf_wren(wren2), .app_wdf_end(end2),
        .app_wdf_data(wdata2), .app_wdf_mask(mask2),
        .app_rd_data({DW{1'b0}}), .app_rd_data_valid(1'b0),
        .busy(busy2), .done(done2), .data_compare_error(err2),
        .err_count(cnt2), .first_err_idx(first2), .calib_lost(lost2));

    int vectors = 0, miscompares = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pattern(input int k);
        logic [DW-1:0] d = '0;
        for (int i = 0; i < DW/32; i++) d[32*i +: 32] = 32'((longint'(k) % 65536) * 65536 + i);
        return d;
    endfunction

    function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] base, input int n);
        longint a = (longint'(base) + longint'(n) * STEP) % (longint'(1) << AW);
        return AW'(a);
    endfunction

    // Responder / memory model state
    int rdy_pct = 100, wdf_pct = 100, rv_pct = 100, corrupt = -1, blk_c = 0, blk_d = 0, junk = 0;
    int n_wc = 0, n_wd = 0, n_rc = 0, n_rd = 0;
    logic [AW-1:0] wa_q[$], rd_q[$];
    logic [DW-1:0] wd_q[$];
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic pend_c, pend_d;
    logic [AW-1:0] pend_a, ra;
    logic [DW-1:0] pend_w;

    initial begin
        app_rdy = 0; app_wdf_rdy = 0; app_rd_data_valid = 0; app_rd_data = '0;
        pend_c = 0; pend_d = 0;
        forever begin
            @(negedge clk);
            app_rdy = $urandom_range(99) < rdy_pct;
            if (app_en && app_cmd == 3'b000 && n_wc == 1 && blk_c > 0) begin app_rdy = 0; blk_c--; end
            app_wdf_rdy = $urandom_range(99) < wdf_pct;
            if (app_wdf_wren && n_wd == 2 && blk_d > 0) begin app_wdf_rdy = 0; blk_d--; end
            app_rd_data_valid = 0;
            if (junk > 0) begin
                app_rd_data = '1; app_rd_data_valid = 1; junk--;
            end else if (rd_q.size() > 0 && $urandom_range(99) < rv_pct) begin
                ra = rd_q.pop_front();
                app_rd_data = mem.exists(ra) ? mem[ra] : '0;
                if (n_rd == corrupt) app_rd_data[0] = ~app_rd_data[0];
                app_rd_data_valid = 1; n_rd++;
            end
            #1;
            if (rst_n && calib) begin
                if (pend_c) begin chk("cmd_hold_en", DW'(app_en), 1); chk("cmd_hold_addr", DW'(app_addr), DW'(pend_a)); end
                if (pend_d) begin chk("wdf_hold_en", DW'(app_wdf_wren), 1); chk("wdf_hold_data", app_wdf_data, pend_w); end
            end
            pend_c = app_en && !app_rdy; pend_a = app_addr;
            pend_d = app_wdf_wren && !app_wdf_rdy; pend_w = app_wdf_data;
            if (app_wdf_wren) begin chk("wdf_end", DW'(app_wdf_end), 1); chk("wdf_mask", DW'(app_wdf_mask), 0); end
            if (app_wdf_wren && app_wdf_rdy) begin
                chk("wr_data", app_wdf_data, pattern(n_wd));
                wd_q.push_back(app_wdf_data); n_wd++;
            end
            if (app_en && app_rdy) begin
                if (app_cmd == 3'b000) begin
                    chk("wr_addr", DW'(app_addr), DW'(exp_addr('0, n_wc)));
                    wa_q.push_back(app_addr); n_wc++;
                    chk("cmd_not_ahead", DW'(n_wc <= n_wd), 1);
                end else begin
                    chk("rd_cmd", DW'(app_cmd), 1);
                    chk("rd_addr", DW'(app_addr), DW'(exp_addr('0, n_rc)));
                    rd_q.push_back(app_addr); n_rc++;
                end
            end
            if (app_wdf_wren && app_wdf_rdy) chk("data_lead", DW'(n_wd - n_wc <= 2), 1);
            while (wa_q.size() > 0 && wd_q.size() > 0) mem[wa_q.pop_front()] = wd_q.pop_front();
        end
    end

    typedef struct {
        int rdy, wdf, rv, corrupt, blk_c, blk_d;
        logic err;
        logic [15:0] cnt, first;
    } vec_t;
    vec_t tbl[7];

    task automatic setup(input vec_t v);
        @(negedge clk); #2;
        rdy_pct = v.rdy; wdf_pct = v.wdf; rv_pct = v.rv; corrupt = v.corrupt; blk_c = v.blk_c; blk_d = v.blk_d;
        n_wc = 0; n_wd = 0; n_rc = 0; n_rd = 0;
        wa_q.delete(); wd_q.delete(); rd_q.delete(); mem.delete();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        chk("start_busy", DW'(busy), 1);
        chk("start_done", DW'(done), 0);
        chk("start_err", DW'(data_compare_error), 0);
        chk("start_cnt", DW'(err_count), 0);
        chk("start_first", DW'(first_err_idx), 0);
        chk("start_lost", DW'(calib_lost), 0);
    endtask

    task automatic wait_done();
        int c = 0;
        while (!done && c < 3000) begin @(negedge clk); c++; end
        chk("done_timeout", DW'(done), 1);
    endtask

    task automatic run_pass(input vec_t v, input bit mid_start);
        setup(v);
        if (mid_start) begin
            repeat (3) @(negedge clk);
            start = 1; @(negedge clk); start = 0;
        end
        wait_done();
        chk("end_busy", DW'(busy), 0);
        chk("end_err", DW'(data_compare_error), DW'(v.err));
        chk("end_cnt", DW'(err_count), DW'(v.cnt));
        chk("end_first", DW'(first_err_idx), DW'(v.first));
        chk("end_lost", DW'(calib_lost), 0);
        chk("n_wr_cmd", DW'(n_wc), NB);
        chk("n_wr_data", DW'(n_wd), NB);
        chk("n_rd_cmd", DW'(n_rc), NB);
        chk("n_rd_data", DW'(n_rd), NB);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, k;
        logic [AW-1:0] got[2];
        tbl[0] = '{100, 100, 100, -1, 0, 0, 1'b0, 16'd0, 16'd0};
        tbl[1] = '{100, 100, 100, -1, 3, 2, 1'b0, 16'd0, 16'd0};
        tbl[2] = '{100, 100, 100,  2, 0, 0, 1'b1, 16'd1, 16'd2};
        tbl[3] = '{ 50,  60,  70, -1, 0, 0, 1'b0, 16'd0, 16'd0};
        tbl[4] = '{ 40,  40,  50,  0, 0, 0, 1'b1, 16'd1, 16'd0};
        tbl[5] = '{ 70,  30,  80,  3, 0, 0, 1'b1, 16'd1, 16'd3};
        tbl[6] = '{ 60,  90,  40, -1, 0, 0, 1'b0, 16'd0, 16'd0};

        rst_n = 0; calib = 0; start = 0; start2 = 0;
        repeat (2) @(negedge clk);
        chk("rst_en", DW'(app_en), 0);
        chk("rst_wren", DW'(app_wdf_wren), 0);
        chk("rst_busy", DW'(busy), 0);
        chk("rst_done", DW'(done), 0);
        chk("rst_err", DW'(data_compare_error), 0);
        chk("rst_cnt", DW'(err_count), 0);
        rst_n = 1;

        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        chk("start_no_calib", DW'(busy), 0);
        calib = 1;

        for (int i = 0; i < 7; i++) run_pass(tbl[i], 1'b0);
        run_pass(tbl[3], 1'b1);

        // Calibration lost during READ, then read data after DONE must be ignored
        setup(tbl[0]);
        c = 0;
        while (!(app_en && app_cmd == 3'b001) && c < 100) begin @(negedge clk); c++; end
        chk("reached_read", DW'(app_cmd), 1);
        #2 calib = 0;
        #1;
        chk("drop_en", DW'(app_en), 0);
        chk("drop_wren", DW'(app_wdf_wren), 0);
        @(negedge clk);
        chk("drop_lost", DW'(calib_lost), 1);
        chk("drop_done", DW'(done), 1);
        chk("drop_busy", DW'(busy), 0);
        chk("drop_err", DW'(data_compare_error), 1);
        #2 calib = 1; junk = 3;
        repeat (5) @(negedge clk);
        chk("junk_cnt", DW'(err_count), 0);
        chk("junk_first", DW'(first_err_idx), 0);

        // Asynchronous reset in the middle of WRITE
        setup(tbl[0]);
        chk("pre_rst_wren", DW'(app_wdf_wren), 1);
        #2 rst_n = 0;
        #1;
        chk("mrst_en", DW'(app_en), 0);
        chk("mrst_wren", DW'(app_wdf_wren), 0);
        chk("mrst_end", DW'(app_wdf_end), 0);
        chk("mrst_addr", DW'(app_addr), 0);
        chk("mrst_data", app_wdf_data, 0);
        chk("mrst_cmd", DW'(app_cmd), 0);
        chk("mrst_busy", DW'(busy), 0);
        chk("mrst_done", DW'(done), 0);
        @(negedge clk); #2 rst_n = 1;
        run_pass(tbl[0], 1'b0);

        // Address wrap on the second instance
        @(negedge clk); start2 = 1;
        @(negedge clk); start2 = 0;
        k = 0;
        for (int j = 0; j < 20; j++) begin
            if (en2 && cmd2 == 3'b000 && k < 2) begin got[k] = addr2; k++; end
            @(negedge clk);
        end
        chk("wrap_n", DW'(k), 2);
        chk("wrap_a0", DW'(got[0]), DW'(exp_addr(WRAP_BASE, 0)));
        chk("wrap_a1", DW'(got[1]), DW'(exp_addr(WRAP_BASE, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
